data_memory_sized: RTL and testbench

Parametrised, byte-addressable data memory for the RV32 core's memory stage. It supersedes the fixed word-only data memory with the following features:
- byte, half and word loads and stores;
- signed or unsigned load extension;
- a valid/ready request port with a registered one-cycle response;
- misalignment and out-of-range error reporting;
- an optional post-reset clear sweep.

---
 rtl/data_memory_sized_if.sv | 29 ++
 rtl/data_memory_sized.sv | 215 +++++++++++++++++++++
 tb/tb_data_memory_sized.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_sized_if.sv
// -----------------------------------------------------------------------------
// data_memory_sized_if
// Request/response bundle for the sized data memory.
//   master : drives req_valid/req_we/req_addr/req_size/req_unsigned/req_wdata,
//            observes req_ready and the registered response (rsp_*).
//   slave  : the memory side, the mirror image of master.
// -----------------------------------------------------------------------------
interface data_memory_sized_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_memory_sized.sv
// -----------------------------------------------------------------------------
// data_memory_sized
// Byte-addressable data memory for the RV32 memory stage: byte/half/word
// loads and stores, signed/unsigned load extension, valid/ready request with a
// registered one-cycle response, misalignment / out-of-range / illegal-size
// error reporting.
// Ports:
//   clk  - single clock, all state on posedge
//   rst  - asynchronous active-high reset
//   bus  - data_memory_sized_if.slave (request + registered response)
// Optional feature: define DMEM_CLEAR_EN to add a post-reset sweep that
// writes zero to every word; req_ready stays low until the sweep is done.
// -----------------------------------------------------------------------------
module data_memory_sized #(
  parameter  int DEPTH_WORDS = 1024,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                clk,
  input  logic                rst,
  data_memory_sized_if.slave  bus
);

  logic [31:0]   mem_q [DEPTH_WORDS];

  logic [AW-1:0] widx_s;
  logic [1:0]    lane_s;
  logic          oor_s;
  logic          err_s;
  logic          accept_s;
  logic          store_s;
  logic [3:0]    be_s;
  logic [31:0]   wdata_al_s;
  logic [31:0]   rword_s;
  logic [7:0]    byte_s;
  logic [15:0]   half_s;
  logic [31:0]   ext_s;

  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q,   rsp_err_d;

`ifdef DMEM_CLEAR_EN
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d;
  logic          clr_we_s;
`endif

  // Request decode: address split, lane enables, error detection, load extraction.
  always_comb begin
    widx_s     = bus.req_addr[AW+1:2];
    lane_s     = bus.req_addr[1:0];
    oor_s      = (bus.req_addr >> (AW + 2)) != 32'd0;
    case (bus.req_size)
      2'b00: begin
        err_s = oor_s;
        be_s  = 4'b0001 << lane_s;
      end
      2'b01: begin
        err_s = oor_s | lane_s[0];
        be_s  = 4'b0011 << {lane_s[1], 1'b0};
      end
      2'b10: begin
        err_s = oor_s | (lane_s != 2'b00);
        be_s  = 4'b1111;
      end
      default: begin
        err_s = 1'b1;
        be_s  = 4'b0000;
      end
    endcase
    accept_s   = bus.req_valid & req_ready_q;
    store_s    = accept_s & bus.req_we & ~err_s;
    // Right-aligned store data moved up to its byte lane.
    wdata_al_s = bus.req_wdata << {lane_s, 3'b000};
    rword_s    = mem_q[widx_s];
    byte_s     = rword_s[{lane_s, 3'b000} +: 8];
    half_s     = rword_s[{lane_s[1], 4'b0000} +: 16];
    case (bus.req_size)
      2'b00: begin
        if (bus.req_unsigned) begin
          ext_s = {24'd0, byte_s};
        end else begin
          ext_s = {{24{byte_s[7]}}, byte_s};
        end
      end
      2'b01: begin
        if (bus.req_unsigned) begin
          ext_s = {16'd0, half_s};
        end else begin
          ext_s = {{16{half_s[15]}}, half_s};
        end
      end
      default: ext_s = rword_s;
    endcase
  end

  // Next response: pulse per accepted request, data only for good loads.
  always_comb begin
    rsp_valid_d = accept_s;
    rsp_err_d   = accept_s & err_s;
    if (accept_s && !bus.req_we && !err_s) begin
      rsp_rdata_d = ext_s;
    end else begin
      rsp_rdata_d = 32'd0;
    end
  end

`ifdef DMEM_CLEAR_EN
  // Clear-sweep FSM: one word per cycle, then open the request port.
  always_comb begin
    state_d     = state_q;
    clr_idx_d   = clr_idx_q;
    clr_we_s    = 1'b0;
    req_ready_d = req_ready_q;
    case (state_q)
      ST_CLEAR: begin
        clr_we_s = 1'b1;
        if (clr_idx_q == {AW{1'b1}}) begin
          state_d     = ST_READY;
          req_ready_d = 1'b1;
          clr_idx_d   = {AW{1'b0}};
        end else begin
          clr_idx_d   = clr_idx_q + {{(AW-1){1'b0}}, 1'b1};
        end
      end
      ST_READY: begin
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = ST_CLEAR;
        req_ready_d = 1'b0;
        clr_idx_d   = {AW{1'b0}};
      end
    endcase
  end

  // Control state registers; reset restarts the sweep from word 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_CLEAR;
      clr_idx_q   <= {AW{1'b0}};
      req_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      req_ready_q <= req_ready_d;
    end
  end

  // Memory array: sweep writes take priority; nothing commits while rst is high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we_s) begin
        mem_q[clr_idx_q] <= 32'd0;
      end else if (store_s) begin
        for (int i = 0; i < 4; i++) begin
          if (be_s[i]) begin
            mem_q[widx_s][8*i +: 8] <= wdata_al_s[8*i +: 8];
          end
        end
      end
    end
  end
`else
  // Without the sweep the port is always open.
  always_comb begin
    req_ready_d = 1'b1;
  end

  // Ready register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready_q <= 1'b1;
    end else begin
      req_ready_q <= req_ready_d;
    end
  end

  // Memory array: lane-masked stores; nothing commits while rst is high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (store_s) begin
        for (int i = 0; i < 4; i++) begin
          if (be_s[i]) begin
            mem_q[widx_s][8*i +: 8] <= wdata_al_s[8*i +: 8];
          end
        end
      end
    end
  end
`endif

  // Response registers; reset drops any in-flight response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_memory_sized.sv
// -----------------------------------------------------------------------------
// tb_data_memory_sized
// Directed bench for data_memory_sized (DEPTH_WORDS = 16). A byte-array model
// predicts every response; a negedge process compares DUT vs model each cycle,
// and literal expectations pin both the DUT and the model on key vectors.
// Works with or without DMEM_CLEAR_EN.
// -----------------------------------------------------------------------------
module tb_data_memory_sized;
  localparam int DEPTH = 16;
  localparam int NBYTES = DEPTH * 4;
`ifdef DMEM_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic clk;
  logic rst;
  data_memory_sized_if bus ();

  data_memory_sized #(.DEPTH_WORDS(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  // Model state
  logic [7:0]  mem_m [NBYTES];
  int          m_cnt = 0;
  logic        m_ready = 1'b0;
  logic        e_valid = 1'b0;
  logic [31:0] e_rdata = 32'd0;
  logic        e_err   = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural effect of one accepted request, from the memory's rules.
  task automatic model_access(input logic we, input logic [31:0] a, input logic [1:0] sz,
                              input logic uns, input logic [31:0] wd);
    int n;
    logic [31:0] v;
    logic bad;
    bad = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0)
          || (a >= 32'(NBYTES));
    e_err   = bad;
    e_rdata = 32'd0;
    if (!bad) begin
      n = 1 << sz;
      if (we) begin
        for (int i = 0; i < n; i++) mem_m[int'(a) + i] = wd[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(mem_m[int'(a) + i]) << (8 * i));
        if (n < 4 && !uns && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        e_rdata = v;
      end
    end
  endtask

  // Model clocking: acceptance, memory update, sweep progress.
  always @(posedge clk) begin
    if (rst) begin
      m_cnt   = 0;
      m_ready = !CLR;
      e_valid = 1'b0;
      e_rdata = 32'd0;
      e_err   = 1'b0;
    end else begin
      e_valid = bus.req_valid && m_ready;
      e_err   = 1'b0;
      e_rdata = 32'd0;
      if (e_valid) model_access(bus.req_we, bus.req_addr, bus.req_size, bus.req_unsigned, bus.req_wdata);
      if (CLR && m_cnt < DEPTH) begin
        m_cnt++;
        if (m_cnt == DEPTH) begin
          for (int i = 0; i < NBYTES; i++) mem_m[i] = 8'h00;
          m_ready = 1'b1;
        end
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (rst) begin
      check("cyc_rst_ready", {31'd0, bus.req_ready}, {31'd0, !CLR});
      check("cyc_rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
      check("cyc_rst_rdata", bus.rsp_rdata, 32'd0);
      check("cyc_rst_err",   {31'd0, bus.rsp_err}, 32'd0);
    end else begin
      check("cyc_ready", {31'd0, bus.req_ready}, {31'd0, m_ready});
      check("cyc_valid", {31'd0, bus.rsp_valid}, {31'd0, e_valid});
      if (e_valid) begin
        check("cyc_rdata", bus.rsp_rdata, e_rdata);
        check("cyc_err",   {31'd0, bus.rsp_err}, {31'd0, e_err});
      end
    end
  end

  task automatic issue(input logic we, input logic [31:0] a, input logic [1:0] sz,
                       input logic uns, input logic [31:0] wd);
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_addr     = a;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_wdata    = wd;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  // Literal pin of the response visible in the current cycle (DUT and model).
  task automatic pin(input string name, input logic [31:0] exp_d, input logic exp_e);
    #1;
    check({name, "_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
    check({name, "_data"},  bus.rsp_rdata, exp_d);
    check({name, "_err"},   {31'd0, bus.rsp_err}, {31'd0, exp_e});
    check({name, "_model"}, e_rdata, exp_d);
  endtask

  task automatic load(input logic [31:0] a, input logic [1:0] sz, input logic uns,
                      input string name, input logic [31:0] exp_d, input logic exp_e);
    issue(1'b0, a, sz, uns, 32'd0);
    idle();
    pin(name, exp_d, exp_e);
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (bus.req_ready !== 1'b1 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 32'd0;
    bus.req_size = 2'd0; bus.req_unsigned = 1'b0; bus.req_wdata = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_ready", {31'd0, bus.req_ready}, {31'd0, !CLR});
    check("reset_valid", {31'd0, bus.rsp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_ready(cyc);
    check("sweep_cycles", cyc, CLR ? 32'(DEPTH) : 32'd0);
    if (CLR) load(32'h3C, 2'd2, 1'b0, "clear_3c", 32'h0, 1'b0);

    // Background data
    issue(1'b1, 32'h0,  2'd2, 1'b0, 32'hCAFE_F00D);
    issue(1'b1, 32'h4,  2'd2, 1'b0, 32'h0102_0304);
    issue(1'b1, 32'h24, 2'd2, 1'b0, 32'hAAAA_5555);
    // Sized store/load
    issue(1'b1, 32'h8,  2'd2, 1'b0, 32'h1122_3344);
    issue(1'b1, 32'h9,  2'd0, 1'b0, 32'hFFFF_FFA5);
    issue(1'b1, 32'hE,  2'd1, 1'b0, 32'h1234_8001);
    idle();
    load(32'h8, 2'd2, 1'b0, "word_8",    32'h1122_A544, 1'b0);
    load(32'h9, 2'd0, 1'b0, "sbyte_9",   32'hFFFF_FFA5, 1'b0);
    load(32'h9, 2'd0, 1'b1, "ubyte_9",   32'h0000_00A5, 1'b0);
    load(32'hA, 2'd1, 1'b0, "shalf_a",   32'h0000_1122, 1'b0);
    load(32'h8, 2'd1, 1'b0, "shalf_8",   32'hFFFF_A544, 1'b0);
    load(32'h8, 2'd1, 1'b1, "uhalf_8",   32'h0000_A544, 1'b0);
    load(32'h8, 2'd0, 1'b0, "sbyte_8",   32'h0000_0044, 1'b0);
    load(32'hE, 2'd1, 1'b0, "shalf_e",   32'hFFFF_8001, 1'b0);
    load(32'hE, 2'd2, 1'b0, "word_e",    32'h0, 1'b1);

    // Errors
    load(32'h3, 2'd1, 1'b0, "err_half3", 32'h0, 1'b1);
    issue(1'b1, 32'h6, 2'd2, 1'b0, 32'hBAD0_BAD0); idle(); pin("err_word6", 32'h0, 1'b1);
    issue(1'b1, 32'h4, 2'd3, 1'b0, 32'hFFFF_FFFF); idle(); pin("err_size3", 32'h0, 1'b1);
    issue(1'b1, 32'(NBYTES), 2'd2, 1'b0, 32'h7777_7777); idle(); pin("err_oor", 32'h0, 1'b1);
    load(32'h4, 2'd2, 1'b0, "after_err_4", 32'h0102_0304, 1'b0);
    load(32'h0, 2'd2, 1'b0, "after_err_0", 32'hCAFE_F00D, 1'b0);

    // Back-to-back store then load of the same word
    issue(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEAD_BEEF);
    issue(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
    #1;
    check("b2b_store_valid", {31'd0, bus.rsp_valid}, 32'd1);
    idle();
    pin("b2b_load", 32'hDEAD_BEEF, 1'b0);

    // Reset in the middle of operation
    issue(1'b1, 32'h20, 2'd2, 1'b0, 32'h1);
    issue(1'b0, 32'h20, 2'd2, 1'b0, 32'h0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_drop_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_drop_rdata", bus.rsp_rdata, 32'd0);
    check("rst_drop_ready", {31'd0, bus.req_ready}, {31'd0, !CLR});
    issue(1'b1, 32'h24, 2'd2, 1'b0, 32'h1234_5678);
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 1'b0;
    wait_ready(cyc);
    check("resweep_cycles", cyc, CLR ? 32'(DEPTH) : 32'd0);
    load(32'h24, 2'd2, 1'b0, "rst_no_commit", CLR ? 32'h0 : 32'hAAAA_5555, 1'b0);
    load(32'h20, 2'd2, 1'b0, "rst_word_20",   CLR ? 32'h0 : 32'h1, 1'b0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
